// File: rtl/riffa2ahir_gen.sv
`default_nettype none
// ============================================================================
// Module   : riffa2ahir_gen
// Purpose  : Bridges one RIFFA RX/TX channel pair onto one AHIR inbound pipe
//            and one AHIR outbound pipe, with elastic FIFOs in each direction.
// Ports    : CLK/RST_N        - clock, asynchronous active-low reset
//            CHNL_RX_*        - RIFFA RX channel (host -> FPGA)
//            CHNL_TX_*        - RIFFA TX channel (FPGA -> host)
//            in_data_pipe_*   - AHIR inbound pipe (bridge writes)
//            out_data_pipe_*  - AHIR outbound pipe (bridge reads)
//            tx_len_in        - runtime TX length in words (TX_LEN_MODE=1)
//            rx/tx_done_count - completed transaction counters
// Options  : `define RIFFA2AHIR_STATS_EN builds the transaction counters;
//            otherwise both count ports are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================

// Small synchronous FIFO, extra pointer bit distinguishes full from empty.
module riffa2ahir_gen_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic             w_do_pop;
  logic             w_do_push;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign w_do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  // Head is forced to zero when empty so the data outputs are clean in reset.
  assign head_o    = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (w_do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (w_do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk_i) begin
    if (w_do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end
endmodule

module riffa2ahir_gen #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int TX_DATA_LEN      = 120,
  parameter int TX_LEN_MODE      = 0,
  parameter int RX_FIFO_DEPTH    = 4,
  parameter int TX_FIFO_DEPTH    = 4
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  // RIFFA RX channel
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN,
  // RIFFA TX channel
  output logic                        CHNL_TX,
  input  logic                        CHNL_TX_ACK,
  output logic [31:0]                 CHNL_TX_LEN,
  output logic [C_PCI_DATA_WIDTH-1:0] CHNL_TX_DATA,
  output logic                        CHNL_TX_DATA_VALID,
  input  logic                        CHNL_TX_DATA_REN,
  // AHIR inbound pipe
  output logic [C_PCI_DATA_WIDTH-1:0] in_data_pipe_write_data,
  output logic                        in_data_pipe_write_req,
  input  logic                        in_data_pipe_write_ack,
  // AHIR outbound pipe
  input  logic [C_PCI_DATA_WIDTH-1:0] out_data_pipe_read_data,
  output logic                        out_data_pipe_read_req,
  input  logic                        out_data_pipe_read_ack,
  // Control / statistics
  input  logic [31:0]                 tx_len_in,
  output logic [15:0]                 rx_done_count,
  output logic [15:0]                 tx_done_count
);
  localparam int NW = C_PCI_DATA_WIDTH / 32;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_ACTIVE = 2'd1, R_WAIT = 2'd2} rx_state_e;
  typedef enum logic       {T_IDLE = 1'b0, T_ACTIVE = 1'b1} tx_state_e;

  // ------------------------------------------------------------------ RX path
  rx_state_e   rx_state_q;
  logic [31:0] rlen_q;
  logic [31:0] rcount_q;
  logic [31:0] w_rcount_d;
  logic        w_rx_full;
  logic        w_rx_empty;
  logic        w_rx_beat;
  logic        w_rx_done;

  assign CHNL_RX_ACK      = (rx_state_q == R_ACTIVE);
  assign CHNL_RX_DATA_REN = (rx_state_q == R_ACTIVE) && !w_rx_full && (rcount_q < rlen_q);
  assign w_rx_beat        = CHNL_RX_DATA_VALID && CHNL_RX_DATA_REN;
  assign w_rcount_d       = w_rx_beat ? (rcount_q + 32'(NW)) : rcount_q;
  // Completion is only declared once the host drops CHNL_RX, so a held
  // CHNL_RX cannot restart the same transaction.
  assign w_rx_done        = (rx_state_q == R_WAIT) && !CHNL_RX;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q <= R_IDLE;
      rlen_q     <= '0;
      rcount_q   <= '0;
    end else begin
      case (rx_state_q)
        R_IDLE: begin
          if (CHNL_RX) begin
            rlen_q     <= CHNL_RX_LEN;
            rcount_q   <= '0;
            rx_state_q <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          rcount_q <= w_rcount_d;
          // A zero length satisfies this on the first cycle without any beat.
          if (w_rcount_d >= rlen_q) rx_state_q <= R_WAIT;
        end
        R_WAIT: begin
          if (!CHNL_RX) rx_state_q <= R_IDLE;
        end
        default: rx_state_q <= R_IDLE;
      endcase
    end
  end

  riffa2ahir_gen_fifo #(
    .WIDTH (C_PCI_DATA_WIDTH),
    .DEPTH (RX_FIFO_DEPTH)
  ) u_rx_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (w_rx_beat),
    .data_i  (CHNL_RX_DATA),
    .pop_i   (in_data_pipe_write_req && in_data_pipe_write_ack),
    .head_o  (in_data_pipe_write_data),
    .full_o  (w_rx_full),
    .empty_o (w_rx_empty)
  );

  assign in_data_pipe_write_req = !w_rx_empty;

  // ------------------------------------------------------------------ TX path
  tx_state_e   tx_state_q;
  logic [31:0] tlen_q;
  logic [31:0] tcount_q;
  logic [31:0] w_tcount_d;
  logic [31:0] w_len;
  logic        w_tx_full;
  logic        w_tx_empty;
  logic        w_tx_pop;
  logic        w_tx_done;
  logic        run_q;
  logic [C_PCI_DATA_WIDTH-1:0] w_tx_head;

  assign w_len              = (TX_LEN_MODE != 0) ? tx_len_in : 32'(TX_DATA_LEN);
  assign CHNL_TX            = (tx_state_q == T_ACTIVE);
  assign CHNL_TX_LEN        = tlen_q;
  assign CHNL_TX_DATA_VALID = (tx_state_q == T_ACTIVE) && !w_tx_empty && (tcount_q < tlen_q);
  assign CHNL_TX_DATA       = w_tx_head;
  assign w_tx_pop           = CHNL_TX_DATA_VALID && CHNL_TX_DATA_REN;
  assign w_tcount_d         = w_tx_pop ? (tcount_q + 32'(NW)) : tcount_q;
  assign w_tx_done          = (tx_state_q == T_ACTIVE) && (w_tcount_d >= tlen_q);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q <= T_IDLE;
      tlen_q     <= '0;
      tcount_q   <= '0;
    end else begin
      case (tx_state_q)
        T_IDLE: begin
          // A zero length parks the channel until a usable length appears.
          if (!w_tx_empty && (w_len != 32'd0)) begin
            tlen_q     <= w_len;
            tcount_q   <= '0;
            tx_state_q <= T_ACTIVE;
          end
        end
        T_ACTIVE: begin
          tcount_q <= w_tcount_d;
          if (w_tcount_d >= tlen_q) tx_state_q <= T_IDLE;
        end
        default: tx_state_q <= T_IDLE;
      endcase
    end
  end

  // Holds the outbound read request low through reset and for the first
  // edge after release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  assign out_data_pipe_read_req = run_q && !w_tx_full;

  riffa2ahir_gen_fifo #(
    .WIDTH (C_PCI_DATA_WIDTH),
    .DEPTH (TX_FIFO_DEPTH)
  ) u_tx_fifo (
    .clk_i   (CLK),
    .rst_n_i (RST_N),
    .push_i  (out_data_pipe_read_req && out_data_pipe_read_ack),
    .data_i  (out_data_pipe_read_data),
    .pop_i   (w_tx_pop),
    .head_o  (w_tx_head),
    .full_o  (w_tx_full),
    .empty_o (w_tx_empty)
  );

  // --------------------------------------------------------------- statistics
  logic unused_ok;

`ifdef RIFFA2AHIR_STATS_EN
  logic [15:0] rx_cnt_q;
  logic [15:0] tx_cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (w_rx_done) rx_cnt_q <= rx_cnt_q + 16'd1;
      if (w_tx_done) tx_cnt_q <= tx_cnt_q + 16'd1;
    end
  end

  assign rx_done_count = rx_cnt_q;
  assign tx_done_count = tx_cnt_q;
  // CHNL_TX_ACK is informational and does not gate any data movement.
  assign unused_ok     = &{1'b0, CHNL_TX_ACK, tx_len_in};
`else
  assign rx_done_count = 16'd0;
  assign tx_done_count = 16'd0;
  assign unused_ok     = &{1'b0, CHNL_TX_ACK, tx_len_in, w_rx_done, w_tx_done};
`endif

endmodule
`default_nettype wire

// File: tb/tb_riffa2ahir_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_riffa2ahir_gen
// Purpose  : Randomized bench for riffa2ahir_gen (32-bit, runtime TX length)
//            against a queue-based transaction model, plus directed checks on
//            a 64-bit, fixed-TX-length instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_riffa2ahir_gen;
`ifdef RIFFA2AHIR_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------- 32-bit instance
  logic        rst_n, chnl_rx, rx_ack, rx_valid, rx_ren;
  logic [31:0] rx_len, rx_data;
  logic        chnl_tx, tx_ack, tx_valid, tx_ren;
  logic [31:0] tx_len, tx_data;
  logic [31:0] pw_data, pr_data, tx_len_in;
  logic        pw_req, pw_ack, pr_req, pr_ack;
  logic [15:0] rx_cnt, tx_cnt;

  riffa2ahir_gen #(
    .C_PCI_DATA_WIDTH (32), .TX_DATA_LEN (120), .TX_LEN_MODE (1),
    .RX_FIFO_DEPTH (DEPTH), .TX_FIFO_DEPTH (DEPTH)
  ) u_dut (
    .CLK (clk), .RST_N (rst_n),
    .CHNL_RX (chnl_rx), .CHNL_RX_ACK (rx_ack), .CHNL_RX_LEN (rx_len),
    .CHNL_RX_DATA (rx_data), .CHNL_RX_DATA_VALID (rx_valid), .CHNL_RX_DATA_REN (rx_ren),
    .CHNL_TX (chnl_tx), .CHNL_TX_ACK (tx_ack), .CHNL_TX_LEN (tx_len),
    .CHNL_TX_DATA (tx_data), .CHNL_TX_DATA_VALID (tx_valid), .CHNL_TX_DATA_REN (tx_ren),
    .in_data_pipe_write_data (pw_data), .in_data_pipe_write_req (pw_req),
    .in_data_pipe_write_ack (pw_ack),
    .out_data_pipe_read_data (pr_data), .out_data_pipe_read_req (pr_req),
    .out_data_pipe_read_ack (pr_ack),
    .tx_len_in (tx_len_in), .rx_done_count (rx_cnt), .tx_done_count (tx_cnt)
  );

  // ---------------------------------------------------------- 64-bit instance
  logic        d_rst_n, d_chnl_rx, d_rx_ack, d_rx_valid, d_rx_ren;
  logic [31:0] d_rx_len, d_tx_len, d_tx_len_in;
  logic [63:0] d_rx_data, d_tx_data, d_pw_data, d_pr_data;
  logic        d_chnl_tx, d_tx_ack, d_tx_valid, d_tx_ren;
  logic        d_pw_req, d_pw_ack, d_pr_req, d_pr_ack;
  logic [15:0] d_rx_cnt, d_tx_cnt;

  riffa2ahir_gen #(
    .C_PCI_DATA_WIDTH (64), .TX_DATA_LEN (3), .TX_LEN_MODE (0),
    .RX_FIFO_DEPTH (DEPTH), .TX_FIFO_DEPTH (DEPTH)
  ) u_dut64 (
    .CLK (clk), .RST_N (d_rst_n),
    .CHNL_RX (d_chnl_rx), .CHNL_RX_ACK (d_rx_ack), .CHNL_RX_LEN (d_rx_len),
    .CHNL_RX_DATA (d_rx_data), .CHNL_RX_DATA_VALID (d_rx_valid), .CHNL_RX_DATA_REN (d_rx_ren),
    .CHNL_TX (d_chnl_tx), .CHNL_TX_ACK (d_tx_ack), .CHNL_TX_LEN (d_tx_len),
    .CHNL_TX_DATA (d_tx_data), .CHNL_TX_DATA_VALID (d_tx_valid), .CHNL_TX_DATA_REN (d_tx_ren),
    .in_data_pipe_write_data (d_pw_data), .in_data_pipe_write_req (d_pw_req),
    .in_data_pipe_write_ack (d_pw_ack),
    .out_data_pipe_read_data (d_pr_data), .out_data_pipe_read_req (d_pr_req),
    .out_data_pipe_read_ack (d_pr_ack),
    .tx_len_in (d_tx_len_in), .rx_done_count (d_rx_cnt), .tx_done_count (d_tx_cnt)
  );

  // ------------------------------------------------------------ model state
  // RX phases: 0 = no transaction, 1 = taking words, 2 = done, host still up.
  int          m_rx_ph, m_tx_ph;
  int unsigned m_rx_len, m_rx_got, m_tx_len, m_tx_sent;
  logic [31:0] m_tx_len_out;
  logic [31:0] m_rxq[$];
  logic [31:0] m_txq[$];
  logic [15:0] m_rx_done, m_tx_done;
  bit          m_run;
  bit          stall;

  task automatic model_clear();
    m_rx_ph = 0; m_tx_ph = 0; m_rx_len = 0; m_rx_got = 0;
    m_tx_len = 0; m_tx_sent = 0; m_tx_len_out = '0;
    m_rxq.delete(); m_txq.delete();
    m_rx_done = '0; m_tx_done = '0; m_run = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rx_ack"}, rx_ack, 0);   check({tag, "_rx_ren"}, rx_ren, 0);
    check({tag, "_chnl_tx"}, chnl_tx, 0); check({tag, "_tx_len"}, tx_len, 0);
    check({tag, "_tx_data"}, tx_data, 0); check({tag, "_tx_valid"}, tx_valid, 0);
    check({tag, "_pw_data"}, pw_data, 0); check({tag, "_pw_req"}, pw_req, 0);
    check({tag, "_pr_req"}, pr_req, 0);   check({tag, "_rx_cnt"}, rx_cnt, 0);
    check({tag, "_tx_cnt"}, tx_cnt, 0);
  endtask

  // New stimulus for the coming clock edge, partly steered by model phase.
  task automatic drive();
    rx_valid = ($urandom_range(0, 3) != 0);
    rx_data  = $urandom;
    if (m_rx_ph == 0 && !chnl_rx && $urandom_range(0, 2) == 0) begin
      chnl_rx = 1'b1;
      rx_len  = $urandom_range(0, 9);
    end else if (m_rx_ph == 2 && $urandom_range(0, 2) == 0) begin
      chnl_rx = 1'b0;
    end
    if ($urandom_range(0, 39) == 0) stall = !stall;
    pw_ack  = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    pr_ack  = ($urandom_range(0, 1) != 0);
    pr_data = $urandom;
    tx_ren  = ($urandom_range(0, 3) != 0);
    tx_ack  = $urandom_range(0, 1);
    if ($urandom_range(0, 29) == 0) tx_len_in = $urandom_range(0, 5);
  endtask

  // Compare outputs with the model, then advance the model over one edge.
  task automatic step();
    bit exp_ren, exp_rreq, exp_tv, rx_beat, pw_pop, pr_push, tx_pop;
    exp_ren  = (m_rx_ph == 1) && (m_rxq.size() < DEPTH) && (m_rx_got < m_rx_len);
    exp_rreq = m_run && (m_txq.size() < DEPTH);
    exp_tv   = (m_tx_ph == 1) && (m_txq.size() != 0) && (m_tx_sent < m_tx_len);
    check("rx_ack", rx_ack, (m_rx_ph == 1));
    check("rx_ren", rx_ren, exp_ren);
    check("pw_req", pw_req, (m_rxq.size() != 0));
    if (m_rxq.size() != 0) check("pw_data", pw_data, m_rxq[0]);
    check("pr_req", pr_req, exp_rreq);
    check("chnl_tx", chnl_tx, (m_tx_ph == 1));
    check("tx_len", tx_len, m_tx_len_out);
    check("tx_valid", tx_valid, exp_tv);
    if (exp_tv) check("tx_data", tx_data, m_txq[0]);
    check("rx_cnt", rx_cnt, STATS ? m_rx_done : 16'd0);
    check("tx_cnt", tx_cnt, STATS ? m_tx_done : 16'd0);

    rx_beat = exp_ren && rx_valid;
    pw_pop  = (m_rxq.size() != 0) && pw_ack;
    pr_push = exp_rreq && pr_ack;
    tx_pop  = exp_tv && tx_ren;

    case (m_rx_ph)
      0: if (chnl_rx) begin m_rx_ph = 1; m_rx_len = rx_len; m_rx_got = 0; end
      1: begin
        if (rx_beat) m_rx_got++;
        if (m_rx_got >= m_rx_len) m_rx_ph = 2;
      end
      default: if (!chnl_rx) begin m_rx_ph = 0; m_rx_done++; end
    endcase
    if (pw_pop)  void'(m_rxq.pop_front());
    if (rx_beat) m_rxq.push_back(rx_data);

    if (m_tx_ph == 0) begin
      if (m_txq.size() != 0 && tx_len_in != 0) begin
        m_tx_ph = 1; m_tx_len = tx_len_in; m_tx_len_out = tx_len_in; m_tx_sent = 0;
      end
    end else if (tx_pop) begin
      void'(m_txq.pop_front());
      m_tx_sent++;
      if (m_tx_sent >= m_tx_len) begin m_tx_ph = 0; m_tx_done++; end
    end
    if (pr_push) m_txq.push_back(pr_data);
    m_run = 1'b1;
  endtask

  initial begin
    logic [63:0] beats[2];
    logic [63:0] pwords[3];
    logic [63:0] got_rx[$];
    logic [63:0] got_tx[$];
    logic [31:0] got_len[$];
    int acc, pushes, falls;
    bit prev_tx;

    rst_n = 0; chnl_rx = 0; rx_len = 0; rx_data = 0; rx_valid = 0;
    tx_ack = 0; tx_ren = 0; pw_ack = 0; pr_ack = 0; pr_data = 0; tx_len_in = 32'd3;
    stall = 0;
    d_rst_n = 0; d_chnl_rx = 0; d_rx_len = 0; d_rx_data = 0; d_rx_valid = 0;
    d_tx_ack = 0; d_tx_ren = 0; d_pw_ack = 0; d_pr_ack = 0; d_pr_data = 0; d_tx_len_in = 0;
    model_clear();

    repeat (3) @(negedge clk);
    #1 check_zero("reset");
    rst_n = 1; d_rst_n = 1;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) begin
        rst_n = 0;
        #1 check_zero("midrst");
        repeat (3) begin @(negedge clk); #1 check_zero("inrst"); end
        model_clear();
        chnl_rx = 0;
        rst_n = 1;
      end
      drive();
      step();
      @(negedge clk); #1;
    end

    // 64-bit RX: length 3 takes two beats; the padding half of beat 2 is kept.
    beats[0] = 64'h1111_2222_3333_4444;
    beats[1] = 64'h5555_6666_7777_8888;
    acc = 0;
    @(negedge clk); #1;
    d_chnl_rx = 1; d_rx_len = 32'd3; d_rx_valid = 1; d_pw_ack = 1;
    for (int i = 0; i < 12; i++) begin
      d_rx_data = (acc < 2) ? beats[acc] : 64'hDEAD_BEEF_DEAD_BEEF;
      if (d_rx_ren && d_rx_valid) acc++;
      if (d_pw_req && d_pw_ack) got_rx.push_back(d_pw_data);
      @(negedge clk); #1;
    end
    check("w64_rx_beats", acc, 2);
    check("w64_rx_words", got_rx.size(), 2);
    if (got_rx.size() == 2) begin
      check("w64_rx_w0", got_rx[0], beats[0]);
      check("w64_rx_w1", got_rx[1], beats[1]);
    end
    check("w64_rx_ack_wait", d_rx_ack, 0);
    d_chnl_rx = 0; d_rx_valid = 0;
    repeat (2) @(negedge clk);
    #1 check("w64_rx_ack_idle", d_rx_ack, 0);
    check("w64_rx_cnt", d_rx_cnt, STATS ? 16'd1 : 16'd0);

    // 64-bit TX, fixed length 3: three words give a 2-beat transaction,
    // then a second transaction that sends the remaining word and waits.
    pwords[0] = 64'hA0A0_0000_0000_0001;
    pwords[1] = 64'hB0B0_0000_0000_0002;
    pwords[2] = 64'hC0C0_0000_0000_0003;
    pushes = 0; falls = 0; prev_tx = 0;
    d_tx_ren = 1;
    for (int i = 0; i < 20; i++) begin
      d_pr_ack  = (pushes < 3);
      d_pr_data = (pushes < 3) ? pwords[pushes] : 64'h0;
      if (d_pr_req && d_pr_ack) pushes++;
      if (d_tx_valid && d_tx_ren) begin
        got_tx.push_back(d_tx_data);
        got_len.push_back(d_tx_len);
      end
      if (prev_tx && !d_chnl_tx) falls++;
      prev_tx = d_chnl_tx;
      @(negedge clk); #1;
    end
    check("w64_tx_beats", got_tx.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (i < got_tx.size()) begin
        check("w64_tx_data", got_tx[i], pwords[i]);
        check("w64_tx_len", got_len[i], 32'd3);
      end
    end
    check("w64_tx_falls", falls, 1);
    check("w64_tx_active", d_chnl_tx, 1);
    check("w64_tx_valid_end", d_tx_valid, 0);
    check("w64_tx_cnt", d_tx_cnt, STATS ? 16'd1 : 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/riffa2ahir_gen.md
Name: riffa2ahir_gen

Overview:
- Next-generation RIFFA channel ↔ AHIR pipe bridge: one RIFFA RX/TX channel pair mapped onto one AHIR inbound pipe and one outbound pipe.
- New over the previous generation:
  - parametrised RX and TX elastic FIFOs;
  - runtime-selectable TX transaction length;
  - RX completion waits for CHNL_RX release, so one transaction cannot retrigger;
  - zero-length transactions are handled;
  - optional transaction statistics.

Parameters:
- C_PCI_DATA_WIDTH, 32: RIFFA/pipe data width; 32, 64 or 128. NW = C_PCI_DATA_WIDTH/32 words per beat.
- TX_DATA_LEN, 120: fixed TX length in 32-bit words, used when TX_LEN_MODE=0.
- TX_LEN_MODE, 0: 0 = fixed TX_DATA_LEN; 1 = length sampled from tx_len_in.
- RX_FIFO_DEPTH, 4: RX buffer entries, power of 2, ≥2.
- TX_FIFO_DEPTH, 4: TX buffer entries, power of 2, ≥2.

Ports:
- CLK  in  1  clock
- RST_N  in  1  asynchronous active-low reset
- CHNL_RX, CHNL_RX_ACK, CHNL_RX_LEN[31:0], CHNL_RX_DATA[W-1:0], CHNL_RX_DATA_VALID, CHNL_RX_DATA_REN: RIFFA RX channel. Only CHNL_RX_ACK and CHNL_RX_DATA_REN are outputs.
- CHNL_TX, CHNL_TX_ACK, CHNL_TX_LEN[31:0], CHNL_TX_DATA[W-1:0], CHNL_TX_DATA_VALID, CHNL_TX_DATA_REN: RIFFA TX channel. Only CHNL_TX_ACK and CHNL_TX_DATA_REN are inputs.
- in_data_pipe_write_data  out  W  / in_data_pipe_write_req  out  1 / in_data_pipe_write_ack  in  1: AHIR inbound pipe.
- out_data_pipe_read_data  in  W / out_data_pipe_read_req  out  1 / out_data_pipe_read_ack  in  1: AHIR outbound pipe.
- tx_len_in  in  32  runtime TX length in words, used in mode 1.
- rx_done_count  out  16  completed RX transactions.
- tx_done_count  out  16  completed TX transactions.

Behaviour:
- One clock. All state is cleared asynchronously while RST_N=0. Reset mid-transaction discards FIFO contents and in-flight counts.
- During reset every output is 0, including CHNL_TX_LEN, both counts and both pipe reqs. out_data_pipe_read_req rises the first cycle after release.
- AHIR handshake: a word moves in any cycle where req=1 and ack=1.
- RIFFA handshake: a beat moves when VALID=1 and REN=1.
- RX FSM:
  - R_IDLE: on CHNL_RX=1, latch rLen=CHNL_RX_LEN and rCount=0, go to R_ACTIVE.
  - R_ACTIVE: CHNL_RX_ACK=1. CHNL_RX_DATA_REN = RX FIFO not full AND rCount<rLen. Each accepted beat is pushed whole (padding words included) and rCount += NW. When rCount ≥ rLen, go to R_WAIT.
  - R_WAIT: CHNL_RX_ACK=0, REN=0. When CHNL_RX=0, go to R_IDLE and increment rx_done_count.
  - rLen=0: R_ACTIVE lasts exactly one cycle, no beat is accepted, then R_WAIT.
- RX FIFO → pipe: in_data_pipe_write_req = FIFO non-empty; write_data = FIFO head. A simultaneous push and pop on a full FIFO is allowed.
- Outbound pipe → TX FIFO: out_data_pipe_read_req = TX FIFO not full. A word is pushed on read_req AND read_ack.
- TX FSM:
  - T_IDLE: when TX FIFO is non-empty and L≠0, latch tLen=L, tCount=0, go to T_ACTIVE. L = TX_DATA_LEN (mode 0) or tx_len_in (mode 1). While L=0 the FSM stays in T_IDLE.
  - T_ACTIVE: CHNL_TX=1, CHNL_TX_LEN=tLen. CHNL_TX_DATA_VALID = FIFO non-empty AND tCount<tLen; CHNL_TX_DATA = FIFO head. Pop on VALID AND REN; tCount += NW. When tCount ≥ tLen, go to T_IDLE next cycle and increment tx_done_count.
  - CHNL_TX_ACK is informational only and does not gate data.
- CHNL_TX_LEN holds its last value in T_IDLE.
- Counts: 32-bit counters compare unsigned; no overflow handling is required below 2^32-NW.
- rx_done_count and tx_done_count wrap modulo 2^16.
- Latency: RIFFA RX beat → write_req is 1 cycle. Pipe word → CHNL_TX_DATA_VALID is 1 cycle when FIFO-ready.
- The RX and TX paths are fully independent and may be active simultaneously.

Optional Feature:
- Macro RIFFA2AHIR_STATS_EN.
- Defined: rx_done_count and tx_done_count are live as described.
- Undefined: no counter registers are built and both ports are tied to 0.

Test Plan:
- RX, W=32, CHNL_RX_LEN=4, pipe ack always 1, CHNL_RX held high for 10 cycles → 4 pipe writes in order. CHNL_RX_ACK drops after the 4th beat. FSM stays in R_WAIT until CHNL_RX falls; rx_done_count=1. No second transaction starts.
- RX backpressure, RX_FIFO_DEPTH=4, write_ack=0 for 20 cycles, len=8 → exactly 4 beats accepted, then REN=0. Releasing ack delivers all 8 words in order.
- TX mode 0, TX_DATA_LEN=3, pipe supplies 5 words, REN=1 → CHNL_TX_LEN=3, 3 beats, CHNL_TX falls, tx_done_count=1. A second transaction starts with 2 words buffered.
- TX mode 1, tx_len_in=0 with data buffered → CHNL_TX stays 0. Setting tx_len_in=2 starts the transaction and 2 beats are sent.
- W=64, RX len=3 → 2 beats accepted (rCount 2 then 4); second beat's padding word is forwarded.
- Assert RST_N=0 mid-TX after 1 of 4 beats → all outputs 0 immediately. After release, FIFOs are empty and CHNL_TX=0.
